// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode codes, initial patterns and prescaler sizing for the LED pattern engine
package led_pattern_pkg;
  localparam logic [2:0] MODE_RUN_L  = 3'd0;
  localparam logic [2:0] MODE_RUN_R  = 3'd1;
  localparam logic [2:0] MODE_BOUNCE = 3'd2;
  localparam logic [2:0] MODE_BAR    = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_COUNT  = 3'd5;

  function automatic logic [31:0] init_pattern(input logic [2:0] m, input int n);
    return (m == MODE_RUN_L || m == MODE_BOUNCE) ? 32'd1 :
           (m == MODE_RUN_R) ? 32'd1 << (n - 1) : 32'd0;
  endfunction

  function automatic int presc_width(input int bp);
    return $clog2(bp);
  endfunction
endpackage

// File: rtl/led_step_prescaler.sv
// led_step_prescaler: counts 0..(BASE_PERIOD>>speed_q)-1 and flags the wrap cycle as a step tick
module led_step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int BASE_PERIOD = 25_000_000
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic       clear,
  input  logic       pause,
  input  logic [1:0] speed_q,
  output logic       tick
);
  localparam int W = presc_width(BASE_PERIOD);
  logic [W-1:0] cnt;
  logic [W-1:0] last;
  assign last = W'((BASE_PERIOD >> speed_q) - 1);
  assign tick = !pause && !clear && cnt == last;
  always_ff @(posedge clk_50M) begin
    if (reset || clear) cnt <= '0;
    else if (!pause) cnt <= tick ? '0 : cnt + 1'b1;
  end
endmodule

// File: rtl/led_pattern_engine.sv
// led_pattern_engine: mode-selectable LED animation with speed divisor, pause and step strobe
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter int N_LED       = 8,
  parameter int BASE_PERIOD = 25_000_000
) (
  input  logic             clk_50M,
  input  logic             reset,
  input  logic [2:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [N_LED-1:0] led,
  output logic             step
);
  logic             load, dir, next_dir, tick, mode_chg, speed_chg;
  logic [2:0]       mode_q;
  logic [1:0]       speed_q;
  logic [N_LED-1:0] init_led, next_led;
  assign mode_chg  = mode != mode_q;
  assign speed_chg = speed != speed_q;
  assign init_led  = N_LED'(init_pattern(mode, N_LED));
  led_step_prescaler #(.BASE_PERIOD(BASE_PERIOD)) u_presc (
    .clk_50M(clk_50M),
    .reset  (reset),
    .clear  (load | mode_chg | speed_chg),
    .pause  (pause),
    .speed_q(speed_q),
    .tick   (tick)
  );
  // dir=1 means moving toward bit0; flips when the lit bit lands on an end
  always_comb begin
    next_led = led;
    next_dir = dir;
    case (mode_q)
      MODE_RUN_L:  next_led = {led[N_LED-2:0], led[N_LED-1]};
      MODE_RUN_R:  next_led = {led[0], led[N_LED-1:1]};
      MODE_BOUNCE: begin
        next_led = dir ? led >> 1 : led << 1;
        next_dir = dir ? !next_led[0] : next_led[N_LED-1];
      end
      MODE_BAR:    next_led = &led ? '0 : {led[N_LED-2:0], 1'b1};
      MODE_BLINK:  next_led = ~led;
      MODE_COUNT:  next_led = led + 1'b1;
      default:     next_led = led;
    endcase
  end
  always_ff @(posedge clk_50M) begin
    if (reset) begin
      led     <= '0;
      step    <= 1'b0;
      load    <= 1'b1;
      mode_q  <= '0;
      speed_q <= '0;
      dir     <= 1'b0;
    end else if (load || mode_chg) begin
      led     <= init_led;
      step    <= 1'b0;
      load    <= 1'b0;
      mode_q  <= mode;
      speed_q <= speed;
      dir     <= 1'b0;
    end else if (speed_chg) begin
      speed_q <= speed;
      step    <= 1'b0;
    end else if (tick && mode_q <= MODE_COUNT) begin
      led  <= next_led;
      dir  <= next_dir;
      step <= 1'b1;
    end else begin
      step <= 1'b0;
    end
  end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed stimulus with a step-index reference model checked every cycle
module tb_led_pattern_engine;
  logic       clk_50M = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] mode = '0;
  logic [1:0] speed = '0;
  logic       pause = 1'b0;
  logic [7:0] led;
  logic       step;
  int checks = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  led_pattern_engine #(.N_LED(8), .BASE_PERIOD(16)) dut (
    .clk_50M(clk_50M),
    .reset  (reset),
    .mode   (mode),
    .speed  (speed),
    .pause  (pause),
    .led    (led),
    .step   (step)
  );

  always #5 clk_50M = ~clk_50M;

  // model: led is a pure function of the mode and the number of steps taken since that mode started
  bit m_load = 1'b1;
  int m_mode = 0, m_spd = 0, m_k = 0, m_cnt = 0;
  bit m_step = 1'b0;

  function automatic logic [7:0] pat(input int m, input int k);
    int j;
    case (m)
      0: return 8'(1 << (k % 8));
      1: return 8'(128 >> (k % 8));
      2: begin
        j = k % 14;
        return j < 8 ? 8'(1 << j) : 8'(1 << (14 - j));
      end
      3: return 8'((1 << (k % 9)) - 1);
      4: return (k % 2) ? 8'hFF : 8'h00;
      5: return 8'(k % 256);
      default: return 8'h00;
    endcase
  endfunction

  always @(posedge clk_50M) begin
    m_step = 1'b0;
    if (reset) begin
      m_load = 1'b1; m_mode = 0; m_spd = 0; m_k = 0; m_cnt = 0;
    end else if (m_load || int'(mode) != m_mode) begin
      m_load = 1'b0; m_mode = int'(mode); m_spd = int'(speed); m_k = 0; m_cnt = 0;
    end else if (int'(speed) != m_spd) begin
      m_spd = int'(speed); m_cnt = 0;
    end else if (!pause) begin
      if (m_cnt == (16 >> m_spd) - 1) begin
        m_cnt = 0;
        if (m_mode < 6) begin
          m_k++;
          m_step = 1'b1;
        end
      end else m_cnt++;
    end
  end

  always @(negedge clk_50M) begin
    if (chk_en) begin
      logic [7:0] exp_led;
      exp_led = m_load ? 8'h00 : pat(m_mode, m_k);
      checks++;
      if (led !== exp_led || step !== m_step) begin
        fails++;
        $display("FAIL model t=%0t led=%02h step=%b required led=%02h step=%b", $time, led, step, exp_led, m_step);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_50M);
  endtask

  task automatic wait_step(input int max, output int c);
    c = 0;
    do begin
      @(negedge clk_50M);
      c++;
    end while (!step && c < max);
    if (!step) c = -1;
  endtask

  int gap, nsteps;
  int bt[14] = '{2, 4, 8, 16, 32, 64, 128, 64, 32, 16, 8, 4, 2, 1};

  initial begin
    cyc(3);
    chk_en = 1'b1;
    lit("reset_led", int'(led), 0);
    lit("reset_step", int'(step), 0);
    reset = 1'b0;
    cyc(1);
    lit("load_led", int'(led), 1);
    for (int i = 0; i < 8; i++) begin
      wait_step(40, gap);
      lit("runl_gap", gap, 16);
      lit("runl_led", int'(led), 1 << ((i + 1) % 8));
    end

    mode = 3'd2; speed = 2'd2;
    cyc(1);
    lit("bounce_init", int'(led), 1);
    lit("bounce_init_step", int'(step), 0);
    for (int i = 0; i < 14; i++) begin
      wait_step(20, gap);
      lit("bounce_gap", gap, 4);
      lit("bounce_led", int'(led), bt[i]);
    end

    mode = 3'd3;
    cyc(1);
    lit("bar_init", int'(led), 0);
    for (int j = 1; j <= 9; j++) begin
      wait_step(20, gap);
      lit("bar_led", int'(led), j == 9 ? 0 : (1 << j) - 1);
    end

    mode = 3'd5; speed = 2'd3;
    cyc(1);
    lit("count_init", int'(led), 0);
    for (int i = 1; i <= 256; i++) begin
      wait_step(10, gap);
      if (i == 1) lit("count_gap", gap, 2);
      if (i == 255) lit("count_ff", int'(led), 255);
      if (i == 256) lit("count_wrap", int'(led), 0);
    end

    mode = 3'd0; speed = 2'd0;
    cyc(1);
    lit("runl_reinit", int'(led), 1);
    cyc(5);
    pause = 1'b1;
    nsteps = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_50M);
      if (step) nsteps++;
    end
    lit("pause_steps", nsteps, 0);
    lit("pause_led", int'(led), 1);
    pause = 1'b0;
    wait_step(40, gap);
    lit("resume_gap", gap, 11);
    lit("resume_led", int'(led), 2);

    cyc(15);
    mode = 3'd4;
    cyc(1);
    lit("mchg_step", int'(step), 0);
    lit("mchg_led", int'(led), 0);
    wait_step(40, gap);
    lit("blink_gap", gap, 16);
    lit("blink_led", int'(led), 255);
    speed = 2'd3;
    cyc(1);
    lit("schg_step", int'(step), 0);
    lit("schg_led", int'(led), 255);
    wait_step(10, gap);
    lit("fast_gap1", gap, 2);
    lit("fast_led1", int'(led), 0);
    wait_step(10, gap);
    lit("fast_gap2", gap, 2);
    lit("fast_led2", int'(led), 255);

    cyc(1);
    reset = 1'b1;
    cyc(1);
    lit("rst_step_led", int'(led), 0);
    lit("rst_step_step", int'(step), 0);
    mode = 3'd6;
    reset = 1'b0;
    nsteps = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_50M);
      if (step) nsteps++;
    end
    lit("rsvd_steps", nsteps, 0);
    lit("rsvd_led", int'(led), 0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
